// File: rtl/gen_seq_det_pkg.sv
// Shared definitions for the generic serial sequence detector.
//   SEQ_W_DEF / CNT_W_DEF : default pattern length and match-counter width
//   state_e               : detector FSM states
package gen_seq_det_pkg;

    localparam int unsigned SEQ_W_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_e;

endpackage

// File: rtl/gen_seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   i_incr  : add one (held at max once saturated)
//   i_clr   : synchronous clear, wins over i_incr
//   o_count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_incr,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_incr && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gen_seq_det.sv
// Generic serial sequence detector with per-bit mask and optional overlap.
//   clk, reset          : clock, asynchronous active-low reset
//   in, in_valid        : serial data bit and its qualifier
//   seq, mask, overlap  : pattern (MSB first), compare mask, overlap mode
//   seq_load            : capture seq/mask/overlap and restart the window
//   cnt_clr             : synchronous clear of match_cnt
//   out                 : registered one-cycle match pulse
//   armed               : a pattern is loaded
//   match_cnt           : saturating match count
module gen_seq_det
    import gen_seq_det_pkg::*;
#(
    parameter int unsigned SEQ_W = SEQ_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic [SEQ_W-1:0] seq,
    input  logic [SEQ_W-1:0] mask,
    input  logic             seq_load,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FCNT_W = $clog2(SEQ_W + 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(SEQ_W);

    state_e            r_state, w_state_d;
    logic [SEQ_W-1:0]  r_hist, w_hist_d, w_hist_shift;
    logic [FCNT_W-1:0] r_fcnt, w_fcnt_d, w_fcnt_inc;
    logic [SEQ_W-1:0]  r_seq, r_mask;
    logic              r_overlap;
    logic              r_out;
    logic              w_match;

    assign w_hist_shift = {r_hist[SEQ_W-2:0], in};
    assign w_fcnt_inc   = (r_fcnt == FCNT_FULL) ? r_fcnt : r_fcnt + FCNT_W'(1);

    always_comb begin
        w_state_d = r_state;
        w_hist_d  = r_hist;
        w_fcnt_d  = r_fcnt;
        w_match   = 1'b0;
        if (seq_load) begin
            // Loading restarts the window; this cycle's data bit is dropped.
            w_state_d = FILL;
            w_hist_d  = '0;
            w_fcnt_d  = '0;
        end else if (in_valid && (r_state != IDLE)) begin
            w_hist_d = w_hist_shift;
            w_fcnt_d = w_fcnt_inc;
            if ((w_fcnt_inc == FCNT_FULL) && (((w_hist_shift ^ r_seq) & r_mask) == '0)) begin
                w_match = 1'b1;
            end
            if (w_match && !r_overlap) begin
                // Non-overlap: demand a completely fresh window.
                w_fcnt_d  = '0;
                w_state_d = FILL;
            end else if (w_fcnt_inc == FCNT_FULL) begin
                w_state_d = ARMED;
            end else begin
                w_state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_hist    <= '0;
            r_fcnt    <= '0;
            r_seq     <= '0;
            r_mask    <= '0;
            r_overlap <= 1'b0;
            r_out     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_hist  <= w_hist_d;
            r_fcnt  <= w_fcnt_d;
            r_out   <= w_match;
            if (seq_load) begin
                r_seq     <= seq;
                r_mask    <= mask;
                r_overlap <= overlap;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_incr (w_match),
        .i_clr  (cnt_clr),
        .o_count(match_cnt)
    );

    assign out   = r_out;
    assign armed = (r_state != IDLE);

endmodule

// File: doc/gen_seq_det.md
GEN_SEQ_DET -- requirements
Module: gen_seq_det

Interface
REQ-001 SHALL have parameter SEQ_W, default 4, meaning the pattern length in bits; the legal range is 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in, input, 1 bit: serial data bit.
REQ-006 SHALL have port in_valid, input, 1 bit: in is sampled only when in_valid is high.
REQ-007 SHALL have port seq, input, SEQ_W bits: target pattern; the MSB is the first bit received.
REQ-008 SHALL have port mask, input, SEQ_W bits: 1 = compare this bit, 0 = don't-care.
REQ-009 SHALL have port seq_load, input, 1 bit: captures seq, mask and overlap into internal registers.
REQ-010 SHALL have port overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-011 SHALL have port cnt_clr, input, 1 bit: synchronous clear of match_cnt.
REQ-012 SHALL have port out, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have port armed, output, 1 bit: high while a pattern is loaded.
REQ-014 SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.

Function
REQ-015 SHALL implement an FSM with states IDLE, FILL and ARMED.
- IDLE is entered at reset.
- seq_load moves the FSM to FILL from any state.
REQ-016 SHALL shift each valid bit into history register hist (shift left, new bit at LSB) and increment fill count fcnt, saturating at SEQ_W.
REQ-017 SHALL ignore in while in IDLE; hist and fcnt do not change.
REQ-018 SHALL move from FILL to ARMED on the valid bit that makes fcnt reach SEQ_W.
REQ-019 SHALL declare a match on a valid bit when, with that bit included:
- the window holds SEQ_W received bits, and
- (hist_next AND mask_r) == (seq_r AND mask_r).
REQ-020 SHALL, on a match, assert out on that same rising edge, for exactly one cycle; out is low in every other cycle.
REQ-021 SHALL, in overlap mode after a match, keep hist and fcnt, so a next match is possible on the next valid bit.
REQ-022 SHALL, in non-overlap mode after a match, clear fcnt and return to FILL, so at least SEQ_W fresh valid bits are needed before the next match.
REQ-023 SHALL, when seq_load is high, clear hist and fcnt and discard that cycle's in bit even if in_valid is high; seq_load takes priority.
REQ-024 SHALL increment match_cnt by 1 per match and saturate at 2^CNT_W-1 with no wrap.
REQ-025 SHALL set match_cnt to 0 when cnt_clr is high, including when a match occurs in the same cycle (cnt_clr wins); out still pulses in that case.
REQ-026 SHALL, when mask_r is all zeros, match on every valid bit once armed in overlap mode, and on every SEQ_W-th valid bit in non-overlap mode.
REQ-027 SHALL not change hist, fcnt or the FSM state on a cycle with in_valid low.
REQ-028 SHALL drive armed high in FILL and ARMED and low in IDLE.

Reset
REQ-029 SHALL, while reset is low, asynchronously force:
- the FSM to IDLE;
- hist, fcnt, seq_r, mask_r, overlap_r, out and match_cnt to 0;
- armed to 0.
REQ-030 SHALL, when reset is asserted mid-pattern, discard the partial window; the pattern must be reloaded before detection resumes.
REQ-031 SHALL release from reset synchronously to clk (the caller supplies a synchronised deassertion); the first valid edge after release behaves as IDLE.

Structure
REQ-032 SHALL place the FSM state typedef (IDLE/FILL/ARMED) and the default SEQ_W/CNT_W constants in shared package gen_seq_det_pkg.
REQ-033 SHALL implement match_cnt in one sub-module, sat_counter, with ports for parameter width, increment, synchronous clear and async active-low reset.
REQ-034 SHALL keep all other logic (shift register, fill counter, compare, FSM) in gen_seq_det.

Verification
REQ-035 SHALL cover: SEQ_W=4, seq=0101, mask=1111, overlap=1, stream 1101011010111 with in_valid=1 -> out pulses on the 6th and 11th bits; match_cnt=2.
REQ-036 SHALL cover: seq=0101, stream 010101 with overlap=1 -> out pulses on the 4th and 6th bits (count 2); the same stream with overlap=0 -> a pulse on the 4th bit only (count 1).
REQ-037 SHALL cover: seq=1001, mask=1001, stream 1111 -> out pulses on the 4th bit; in_valid gaps inserted mid-stream -> the same result, delayed.
REQ-038 SHALL cover: seq_load with in_valid=1 in the same cycle -> that bit is discarded; no match until 4 further valid bits arrive; reset asserted mid-stream -> out=0, armed=0, match_cnt=0 immediately.
REQ-039 SHALL cover: CNT_W=2, 5 matches -> match_cnt sticks at 3; cnt_clr coincident with a match -> match_cnt=0 and out=1.
REQ-040 SHALL cover: after reset with no seq_load, 20 valid bits of any value -> out stays 0 and armed stays 0.
